// File: rtl/servant_acc_wb_pkg.sv
// Shared definitions for the servant accelerator Wishbone slave.
// Holds the bus FSM state encoding, register offsets within the register
// region, CTRL/STATUS bit positions and the address bit that splits the
// register region from the BRAM window.
package servant_acc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Register offsets, selected by adr[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DONECNT = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  // CTRL bits (write-only)
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  // STATUS bits (read-only)
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  // adr[29] = 1 selects the BRAM window, 0 selects the registers
  localparam int REGION_BIT = 29;

endpackage

// File: rtl/servant_acc_regs.sv
// Accelerator control/status register file.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_wr               one-cycle register write strobe
//   i_sel              register offset (CTRL/STATUS/DONE_CNT/SCRATCH)
//   i_wdata            write data
//   i_acc_busy         accelerator running (level)
//   i_acc_done         accelerator finished (one-cycle pulse)
//   o_rdata            combinational read data for i_sel
//   o_acc_start        one-cycle start pulse, the cycle after a CTRL start write
module servant_acc_regs
  import servant_acc_wb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [1:0]        i_sel,
  input  logic [31:0]       i_wdata,
  input  logic              i_acc_busy,
  input  logic              i_acc_done,
  output logic [31:0]       o_rdata,
  output logic              o_acc_start
);

  logic             r_start;
  logic             r_done_flag;
  logic             r_start_err;
  logic [CNT_W-1:0] r_done_cnt;
  logic [31:0]      r_scratch;

  logic w_ctrl_wr;
  logic w_start_req;
  logic w_clr;
  logic w_cnt_wr;
  logic w_scr_wr;
  logic [CNT_W-1:0] w_done_inc;

  assign w_ctrl_wr   = i_wr && (i_sel == REG_CTRL);
  assign w_start_req = w_ctrl_wr && i_wdata[CTRL_START_BIT];
  assign w_clr       = w_ctrl_wr && i_wdata[CTRL_CLR_BIT];
  assign w_cnt_wr    = i_wr && (i_sel == REG_DONECNT);
  assign w_scr_wr    = i_wr && (i_sel == REG_SCRATCH);
  assign w_done_inc  = {{(CNT_W-1){1'b0}}, i_acc_done};

  // Control state: start pulse, sticky flags, done counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start     <= 1'b0;
      r_done_flag <= 1'b0;
      r_start_err <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      r_start <= w_start_req && !i_acc_busy;
      // A start refused because of busy is recorded even if clear is also written
      if (w_start_req && i_acc_busy)
        r_start_err <= 1'b1;
      else if (w_clr)
        r_start_err <= 1'b0;
      // A done event beats a same-cycle clear
      if (i_acc_done)
        r_done_flag <= 1'b1;
      else if (w_clr)
        r_done_flag <= 1'b0;
      // A done coinciding with a counter write is counted on top of the new value
      if (w_cnt_wr)
        r_done_cnt <= i_wdata[CNT_W-1:0] + w_done_inc;
      else
        r_done_cnt <= r_done_cnt + w_done_inc;
    end
  end

  // Scratch is pure data and carries no reset
  always_ff @(posedge i_clk) begin
    if (w_scr_wr)
      r_scratch <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    case (i_sel)
      REG_STATUS: begin
        o_rdata[STAT_BUSY_BIT] = i_acc_busy;
        o_rdata[STAT_DONE_BIT] = r_done_flag;
        o_rdata[STAT_ERR_BIT]  = r_start_err;
      end
      REG_DONECNT: o_rdata = 32'(r_done_cnt);
      REG_SCRATCH: o_rdata = r_scratch;
      default:     o_rdata = '0;
    endcase
  end

  assign o_acc_start = r_start;

endmodule

// File: rtl/servant_acc_wb.sv
// Wishbone slave for the accelerator port of the servant bus mux.
// Decodes register accesses and a window onto the accelerator BRAM, and
// returns registered read data with a registered single-cycle ack.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wb_adr/dat/we/cyc          Wishbone request from the mux
//   o_wb_rdt, o_wb_ack           registered read data and one-cycle ack
//   o_acc_start                  one-cycle accelerator start pulse
//   i_acc_busy, i_acc_done       accelerator status
//   o_bram_en/we/addr/wdata      BRAM port, driven in the request cycle
//   i_bram_rdata                 BRAM read data, valid RD_LAT cycles after en
module servant_acc_wb
  import servant_acc_wb_pkg::*;
#(
  parameter int BRAM_AW = 10,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_we,
  input  logic               i_wb_cyc,
  output logic [31:0]        o_wb_rdt,
  output logic               o_wb_ack,
  output logic               o_acc_start,
  input  logic               i_acc_busy,
  input  logic               i_acc_done,
  output logic               o_bram_en,
  output logic               o_bram_we,
  output logic [BRAM_AW-1:0] o_bram_addr,
  output logic [31:0]        o_bram_wdata,
  input  logic [31:0]        i_bram_rdata
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t      r_state;
  state_t      w_next;
  logic        r_ack;
  logic [31:0] r_rdt;
  logic [1:0]  r_rd_cnt;

  logic        w_is_bram;
  logic [1:0]  w_sel;
  logic        w_reg_wr;
  logic        w_reg_rd;
  logic        w_bram_cap;
  logic [31:0] w_reg_rdata;
  logic        w_unused;

  assign w_is_bram = i_wb_adr[REGION_BIT];
  assign w_sel     = i_wb_adr[3:2];
  assign w_unused  = ^i_wb_adr;

  servant_acc_regs #(.CNT_W(CNT_W)) u_regs (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr        (w_reg_wr),
    .i_sel       (w_sel),
    .i_wdata     (i_wb_dat),
    .i_acc_busy  (i_acc_busy),
    .i_acc_done  (i_acc_done),
    .o_rdata     (w_reg_rdata),
    .o_acc_start (o_acc_start)
  );

  // Next state and request-cycle strobes
  always_comb begin
    w_next     = r_state;
    w_reg_wr   = 1'b0;
    w_reg_rd   = 1'b0;
    w_bram_cap = 1'b0;
    o_bram_en  = 1'b0;
    o_bram_we  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // BRAM strobes are combinational so the BRAM samples the address
        // on the same edge that leaves IDLE; keep them quiet under reset.
        if (i_wb_cyc && !i_rst) begin
          if (w_is_bram) begin
            o_bram_en = 1'b1;
            o_bram_we = i_wb_we;
          end else begin
            w_reg_wr = i_wb_we;
            w_reg_rd = !i_wb_we;
          end
        end
        if (i_wb_cyc)
          w_next = (w_is_bram && !i_wb_we) ? ST_RD_WAIT : ST_ACK;
      end
      ST_RD_WAIT: begin
        // A dropped cyc abandons the read without touching the read data
        if (!i_wb_cyc) begin
          w_next = ST_IDLE;
        end else if (r_rd_cnt == 2'd1) begin
          w_bram_cap = 1'b1;
          w_next     = ST_ACK;
        end
      end
      ST_ACK:  w_next = ST_HOLD;
      ST_HOLD: if (!i_wb_cyc) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, ack, read data and BRAM latency counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_rdt    <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ST_ACK);
      if (w_reg_rd)
        r_rdt <= w_reg_rdata;
      else if (w_bram_cap)
        r_rdt <= i_bram_rdata;
      if (r_state == ST_IDLE)
        r_rd_cnt <= LAT;
      else if (r_state == ST_RD_WAIT)
        r_rd_cnt <= r_rd_cnt - 2'd1;
    end
  end

  assign o_wb_ack     = r_ack;
  assign o_wb_rdt     = r_rdt;
  assign o_bram_addr  = i_wb_adr[BRAM_AW+1:2];
  assign o_bram_wdata = i_wb_dat;

endmodule

// File: tb/tb_servant_acc_wb.sv
// Bench for servant_acc_wb: two instances (BRAM latency 1 and 3) share the
// same bus and accelerator stimulus; a transaction-level model predicts
// ack cycles, read data, start pulses and BRAM strobes for both.
module tb_servant_acc_wb;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, dat;
  logic        we, cyc, busy, done;

  logic [31:0]   rdt    [2];
  logic          ack    [2];
  logic          start  [2];
  logic          en     [2];
  logic          bwe    [2];
  logic [AW-1:0] baddr  [2];
  logic [31:0]   bwdata [2];
  logic [31:0]   brdata [2];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  servant_acc_wb #(.BRAM_AW(AW), .RD_LAT(1), .CNT_W(16)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_cyc(cyc), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_acc_start(start[0]),
    .i_acc_busy(busy), .i_acc_done(done), .o_bram_en(en[0]), .o_bram_we(bwe[0]),
    .o_bram_addr(baddr[0]), .o_bram_wdata(bwdata[0]), .i_bram_rdata(brdata[0])
  );

  servant_acc_wb #(.BRAM_AW(AW), .RD_LAT(3), .CNT_W(16)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_cyc(cyc), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_acc_start(start[1]),
    .i_acc_busy(busy), .i_acc_done(done), .o_bram_en(en[1]), .o_bram_we(bwe[1]),
    .o_bram_addr(baddr[1]), .o_bram_wdata(bwdata[1]), .i_bram_rdata(brdata[1])
  );

  // Synchronous BRAM models, one per instance
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_bram
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem  [1024];
      logic [31:0] pipe [LAT];
      always @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (en[g] && bwe[g]) begin
          mem[baddr[g]] <= bwdata[g];
        end
        if (en[g] && !bwe[g]) pipe[0] <= mem[baddr[g]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign brdata[g] = pipe[LAT-1];
    end
  endgenerate

  // Reference model state
  logic [31:0]   ref_mem [1024];
  logic          m_flag, m_err;
  logic [15:0]   m_cnt;
  logic [31:0]   m_scratch;

  // Expected bus events for the transaction in flight
  int            ack_at  [2];
  int            obs_ack [2];
  int            en_at, start_at, launch_cyc;
  logic          exp_rd, exp_we;
  logic [31:0]   pend_data, exp_wdata;
  logic [AW-1:0] exp_addr;
  logic [31:0]   rdt_exp [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Per-cycle comparison of every output of both instances
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cycle == ack_at[d] && exp_rd) rdt_exp[d] = pend_data;
      chk($sformatf("ack_dut%0d", d), 32'(ack[d]), 32'(cycle == ack_at[d]));
      if (ack[d]) obs_ack[d] = cycle;
      chk($sformatf("rdt_dut%0d", d), rdt[d], rdt_exp[d]);
      chk($sformatf("start_dut%0d", d), 32'(start[d]), 32'(cycle == start_at));
      chk($sformatf("bram_en_dut%0d", d), 32'(en[d]), 32'(cycle == en_at));
      if (cycle == en_at) begin
        chk($sformatf("bram_we_dut%0d", d), 32'(bwe[d]), 32'(exp_we));
        chk($sformatf("bram_addr_dut%0d", d), 32'(baddr[d]), 32'(exp_addr));
        if (exp_we) chk($sformatf("bram_wdata_dut%0d", d), bwdata[d], exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_read(input logic [1:0] sel, input logic b);
    case (sel)
      2'd1:    return {29'b0, m_err, m_flag, b};
      2'd2:    return {16'b0, m_cnt};
      2'd3:    return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  // Present a request during the current cycle and predict its effects
  task automatic launch(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic b, input logic dn);
    int   p;
    int   wi;
    logic is_bram, wr_ctrl, start_req, clr;
    logic [1:0] sel;
    p = cycle;
    is_bram = a[29];
    sel = a[3:2];
    wi = int'(a[11:2]);
    adr = a; dat = d; we = w; busy = b; done = dn; cyc = 1'b1;
    launch_cyc = p;
    obs_ack = '{-1, -1};
    start_at = -1;
    en_at = -1;
    exp_rd = 1'b0;
    if (is_bram) begin
      en_at = p; exp_we = w; exp_addr = a[11:2]; exp_wdata = d;
      if (w) begin
        ref_mem[wi] = d;
        ack_at = '{p + 1, p + 1};
      end else begin
        exp_rd = 1'b1;
        pend_data = ref_mem[wi];
        ack_at = '{p + 2, p + 4};
      end
    end else begin
      ack_at = '{p + 1, p + 1};
      if (!w) begin
        exp_rd = 1'b1;
        pend_data = reg_read(sel, b);
      end
    end
    wr_ctrl   = !is_bram && w && sel == 2'd0;
    start_req = wr_ctrl && d[0];
    clr       = wr_ctrl && d[1];
    if (start_req && !b) start_at = p + 1;
    m_err  = (start_req && b) ? 1'b1 : (clr ? 1'b0 : m_err);
    m_flag = dn ? 1'b1 : (clr ? 1'b0 : m_flag);
    if (!is_bram && w && sel == 2'd2) m_cnt = d[15:0] + 16'(dn);
    else                              m_cnt = m_cnt + 16'(dn);
    if (!is_bram && w && sel == 2'd3) m_scratch = d;
  endtask

  // Keep cyc up until both instances have acked plus 'hold' cycles, then idle
  task automatic finish(input int hold);
    int last;
    step();
    done = 1'b0;
    last = (ack_at[0] > ack_at[1]) ? ack_at[0] : ack_at[1];
    while (cycle < last + hold) step();
    cyc = 1'b0;
    we = 1'b0;
    step();
    step();
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic b, input logic dn, input int hold);
    launch(a, d, w, b, dn);
    finish(hold);
  endtask

  task automatic abort_read(input logic [31:0] a, input logic b);
    launch(a, 32'h0, 1'b0, b, 1'b0);
    ack_at = '{-1, -1};
    exp_rd = 1'b0;
    step();
    cyc = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    m_flag = 1'b1;
    m_cnt = m_cnt + 16'd1;
    step();
    done = 1'b0;
    step();
  endtask

  initial begin
    adr = 32'h6000_0000; dat = '0; we = 1'b0; cyc = 1'b1; busy = 1'b0; done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    m_flag = 1'b0; m_err = 1'b0; m_cnt = '0; m_scratch = '0;
    ack_at = '{-1, -1}; obs_ack = '{-1, -1};
    en_at = -1; start_at = -1; launch_cyc = 0;
    exp_rd = 1'b0; exp_we = 1'b0; pend_data = '0; exp_wdata = '0; exp_addr = '0;
    rdt_exp = '{32'h0, 32'h0};
    #1 rst = 1'b1;

    // Reset held with a BRAM read request pending; released mid-request
    repeat (4) step();
    rst = 1'b0;
    launch(32'h6000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    finish(0);
    chk("post_reset_rd_data", rdt[0], 32'hA5A5_A5A5);
    chk("post_reset_rd_lat_l1", 32'(obs_ack[0] - launch_cyc), 32'd2);

    // Scratch write then read, cyc held 3 cycles after the read ack
    txn(32'h4000_000C, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0);
    chk("scratch_wr_lat", 32'(obs_ack[0] - launch_cyc), 32'd1);
    txn(32'h4000_000C, 32'h0, 1'b0, 1'b0, 1'b0, 3);
    chk("scratch_rd_lat", 32'(obs_ack[0] - launch_cyc), 32'd1);
    chk("scratch_rd_data", rdt[0], 32'hDEAD_BEEF);

    // BRAM word 5 write then read through both latencies
    txn(32'h6000_0014, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 0);
    txn(32'h6000_0014, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("bram_rd_data_l1", rdt[0], 32'h1234_5678);
    chk("bram_rd_data_l3", rdt[1], 32'h1234_5678);
    chk("bram_rd_lat_l1", 32'(obs_ack[0] - launch_cyc), 32'd2);
    chk("bram_rd_lat_l3", 32'(obs_ack[1] - launch_cyc), 32'd4);

    // Start while idle pulses; start while busy sets the error flag
    txn(32'h4000_0000, 32'h1, 1'b1, 1'b0, 1'b0, 0);
    txn(32'h4000_0000, 32'h1, 1'b1, 1'b1, 1'b0, 0);
    txn(32'h4000_0004, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("status_start_err", rdt[0], 32'h4);

    // Done coincident with clear: done wins, error cleared, counter bumps
    txn(32'h4000_0000, 32'h2, 1'b1, 1'b0, 1'b1, 0);
    txn(32'h4000_0004, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("status_done_set", rdt[0], 32'h2);
    txn(32'h4000_0008, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("donecnt_after_done", rdt[0], 32'h1);
    txn(32'h4000_0000, 32'h2, 1'b1, 1'b0, 1'b0, 0);
    txn(32'h4000_0004, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("status_cleared", rdt[0], 32'h0);

    // Counter wrap
    txn(32'h4000_0008, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 0);
    pulse_done();
    txn(32'h4000_0008, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("donecnt_wrap", rdt[1], 32'h0);

    // Aborted BRAM read keeps previous read data; next access is normal
    txn(32'h4000_000C, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    abort_read(32'h6000_0014, 1'b0);
    chk("abort_keeps_rdt_l1", rdt[0], 32'hDEAD_BEEF);
    chk("abort_keeps_rdt_l3", rdt[1], 32'hDEAD_BEEF);
    txn(32'h6000_0014, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    chk("after_abort_rd_l3", rdt[1], 32'h1234_5678);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int          op, hold;
      logic [31:0] a, d;
      logic        b, dn;
      op   = $urandom_range(0, 9);
      a    = $urandom;
      d    = $urandom;
      a[31:30] = 2'b01;
      b    = ($urandom_range(0, 3) == 0);
      dn   = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(0, 2);
      case (op)
        0, 1: begin a[29] = 1'b0; txn(a, d, 1'b1, b, dn, hold); end
        2, 3: begin a[29] = 1'b0; txn(a, d, 1'b0, b, dn, hold); end
        4, 5: begin a[29] = 1'b1; txn(a, d, 1'b1, b, dn, hold); end
        6, 7: begin a[29] = 1'b1; txn(a, d, 1'b0, b, dn, hold); end
        8:    begin a[29] = 1'b1; abort_read(a, b); end
        default: pulse_done();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
